// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with a registered one-hot grant and an optional hold-limit timeout.
// Define RR_IDX_EN to add the registered binary winner index output gnt_idx.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic       gnt_valid
`ifdef RR_IDX_EN
    ,
    output logic [2:0] gnt_idx
`endif
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam bit               HOLD_EN  = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    logic [0:0]       state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       holder_q, holder_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       gnt_q, gnt_d;
    logic             vld_q, vld_d;

    logic [7:0] others;
    logic [3:0] pick_idle;
    logic [3:0] pick_next;
    logic       forced;

    // Returns {found, index} of the first set bit of r, scanning upward from start with wrap 7->0.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] pos;
        res = '0;
        for (int i = 7; i >= 0; i--) begin
            pos = start + 3'(i);
            if (r[pos]) begin
                res = {1'b1, pos};
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

    assign others    = req & ~onehot8(holder_q);
    assign pick_idle = rr_pick(req, ptr_q);
    assign pick_next = rr_pick(others, holder_q + 3'd1);
    assign forced    = HOLD_EN && (cnt_q == HOLD_LIM) && req[holder_q] && (|others);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        holder_d = holder_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        case (state_q)
            IDLE: begin
                if (pick_idle[3]) begin
                    gnt_d    = onehot8(pick_idle[2:0]);
                    holder_d = pick_idle[2:0];
                    cnt_d    = CNT_W'(1);
                    state_d  = GRANT;
                end else begin
                    gnt_d = '0;
                end
            end
            GRANT: begin
                if (!req[holder_q] || forced) begin
                    // Holder's own request is zero on a voluntary release, so others == req there.
                    ptr_d = holder_q + 3'd1;
                    if (pick_next[3]) begin
                        gnt_d    = onehot8(pick_next[2:0]);
                        holder_d = pick_next[2:0];
                        cnt_d    = CNT_W'(1);
                    end else begin
                        gnt_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (HOLD_EN && (cnt_q >= HOLD_LIM)) begin
                    cnt_d = HOLD_LIM;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        vld_d = |gnt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            holder_q <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            holder_q <= holder_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            vld_q    <= vld_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = vld_q;

`ifdef RR_IDX_EN
    logic [2:0] idx_q, idx_d;

    always_comb begin
        idx_d = (|gnt_d) ? holder_d : 3'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign gnt_idx = idx_q;
`endif

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_gnt_valid   : assert property (@(posedge clk) disable iff (rst) vld_q == (|gnt_q));

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- 8-requester round-robin arbiter with registered one-hot grant.
- Sits directly upstream of the team's 8-to-3 one-hot encoder: gnt[7:0] drives the encoder's 8-bit one-hot input to produce the winning index.
- Grant is held while the winner keeps its request high, with an optional hold-limit timeout for fairness.

Parameters:
- MAX_HOLD, 16, max consecutive grant cycles per win when others are waiting; 0 = unlimited
- CNT_W, 8, hold counter width; MAX_HOLD must fit in CNT_W bits

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  8  request lines, bit i = requester i, level-sensitive
- gnt  output  8  registered grant, one-hot or all-zero
- gnt_valid  output  1  registered, equals |gnt
- gnt_idx  output  3  binary index of the granted bit; present only with RR_IDX_EN

Behaviour:
- Clock/reset: one clock (clk); reset (rst) is asynchronous and active-high.
- rst asserted at any time, including mid-grant: immediately clears gnt=0, gnt_valid=0, gnt_idx=0, ptr=0, hold_cnt=0, state=IDLE.
- Internal state:
  - ptr[2:0]: highest-priority position.
  - holder[2:0]: current winner.
  - hold_cnt[CNT_W-1:0].
- Search: from ptr upward, wrapping 7->0; the first set bit wins.
- FSM states: IDLE, GRANT.
- IDLE:
  - req==0: stay; gnt=0.
  - Any req bit set: at the next edge, gnt=one-hot(winner), holder=winner, hold_cnt=1, go to GRANT.
  - Latency is 1 cycle from req to gnt.
- GRANT, normal hold: req[holder]=1 and no timeout: gnt unchanged, hold_cnt+1 (saturates at all-ones).
- GRANT, voluntary release (req[holder]=0):
  - ptr <= holder+1 (mod 8).
  - Same edge: if another req bit is set, grant the next winner searching from holder+1 (back-to-back, no bubble), hold_cnt=1.
  - Otherwise gnt=0 and go to IDLE.
- GRANT, forced release:
  - Condition: MAX_HOLD!=0, hold_cnt==MAX_HOLD, req[holder]=1, and at least one other req bit set.
  - Re-grant at that edge to the next winner searching from holder+1, excluding holder; ptr <= holder+1; hold_cnt=1.
- Timeout with no other requester: holder keeps the grant; hold_cnt saturates at MAX_HOLD; forced release re-evaluates every cycle.
- MAX_HOLD=0: no forced release ever.
- Wrap-around: holder=7 releases, so ptr becomes 0.
- Invariants:
  - gnt is never multi-hot.
  - gnt bit i is never set while req[i] was 0 at the granting edge.
  - gnt_valid==|gnt every cycle.
- A request dropped while not granted is simply not considered; there is no latching of requests.

Optional Feature:
- Macro: RR_IDX_EN.
- Defined:
  - Adds port gnt_idx[2:0], registered and updated on the same edge as gnt, holding the binary index of the winner.
  - Holds 0 when gnt=0 (qualify with gnt_valid).
  - Lets downstream logic skip a separate encoder.
- Undefined: the gnt_idx port and its register are absent; downstream encodes gnt itself.

Test Plan:
- Reset with req=8'hFF asserted -> gnt=0, gnt_valid=0 during rst; first edge after release gives gnt=8'h01, gnt_valid=1.
- req=8'h10 single pulse held 3 cycles then dropped -> gnt=8'h10 for 3 cycles starting 1 cycle after req, then gnt=0 and state IDLE; next grant search starts at bit 5.
- req=8'h81 constant, each winner drops its req for 1 cycle after 2 cycles of grant -> grants alternate 8'h01, 8'h80, 8'h01, covering wrap 7->0 and back-to-back handoff without a bubble.
- MAX_HOLD=4, req=8'h06 held constant -> gnt=8'h02 for exactly 4 cycles, then 8'h04 for 4 cycles, then 8'h02, repeating.
- MAX_HOLD=4, req=8'h08 alone for 10 cycles -> gnt=8'h08 throughout; no release and no glitch to 0.
- rst pulsed asynchronously (between clock edges) while gnt=8'h20 -> gnt=0 immediately; with RR_IDX_EN, gnt_idx=5 before reset and 0 after, and after reset with req=8'h20 the grant is 8'h20 again with gnt_idx=5.
